// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// The request is a valid/ready handshake; the response is a single-cycle valid pulse.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Multi-cycle RISC-V fetch stage: owns the PC, fetches one word per instruction,
// holds it for decode, and resolves the next PC from brnch/alu_zero at ack.
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_if.master     imem,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              brnch,
    input  logic              alu_zero,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] imm_b;
    logic [ADDR_W-1:0] next_pc;

    assign imm_b = {{(ADDR_W-12){instr_q[31]}}, instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};

    // Wraps modulo 2^ADDR_W; only misalignment is an error.
    assign next_pc = pc_q + ((brnch & alu_zero) ? imm_b : ADDR_W'(4));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
        unique case (state_q)
            S_REQ: begin
                if (imem.imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    instr_d = imem.imem_rsp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ack) begin
                    if (next_pc[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Request is masked while reset is held so the reset cycle never issues.
    always_comb begin
        imem.imem_req_valid = (state_q == S_REQ) & ~reset;
        imem.imem_addr      = pc_q;
        instr_valid         = (state_q == S_HOLD);
    end

    assign opcode    = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign funct3    = instr_q[14:12];
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign funct7    = instr_q[31:25];
    assign pc        = pc_q;
    assign fetch_err = err_q;

endmodule
